// File: rtl/axi_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4 arbiter.
//   arb_state_t : grant FSM state (IDLE, IFU_RD, LSU_RD, LSU_WR)
//   BURST_*     : AXI burst type encodings
//   RESP_*      : AXI response encodings
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } arb_state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_arbiter_if.sv
// AXI4 channel bundle (AR, R, AW, W, B).
//   master   : view of the side that issues requests (drives AR/AW/W valids)
//   slave    : view of the side that accepts requests (drives readies, R, B)
//   rd_slave : slave view restricted to the read channels (read-only masters)
interface axi_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) ();

   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     arid;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;

   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ID_W-1:0]     rid;
   logic                rlast;

   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [ID_W-1:0]     awid;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     bid;

   modport master (
      output araddr, arvalid, arid, arlen, arsize, arburst,
      input  arready,
      input  rdata, rresp, rvalid, rid, rlast,
      output rready,
      output awaddr, awvalid, awid, awlen, awsize, awburst,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid, bid,
      output bready
   );

   modport slave (
      input  araddr, arvalid, arid, arlen, arsize, arburst,
      output arready,
      output rdata, rresp, rvalid, rid, rlast,
      input  rready,
      input  awaddr, awvalid, awid, awlen, awsize, awburst,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid, bid,
      input  bready
   );

   modport rd_slave (
      input  araddr, arvalid, arid, arlen, arsize, arburst,
      output arready,
      output rdata, rresp, rvalid, rid, rlast,
      input  rready
   );

endinterface

// File: rtl/axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// Fixed priority LSU write > LSU read > IFU read, one transaction in flight,
// channels forwarded combinationally once granted.
// Ports:
//   clock, reset : core clock, synchronous active-high reset
//   ifu          : IFU read channels (AR/R), arbiter is the slave
//   lsu          : LSU AR/R/AW/W/B channels, arbiter is the slave
//   s            : SoC slave port, arbiter is the master
module axi_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic            clock,
   input  logic            reset,
   axi_arbiter_if.rd_slave ifu,
   axi_arbiter_if.slave    lsu,
   axi_arbiter_if.master   s
);

   arb_state_t        state, state_next;
   logic              addr_acc, addr_acc_next;

   logic              rd_active, rd_lsu, wr_active;
   logic [ADDR_W-1:0] m_araddr;
   logic [ID_W-1:0]   m_arid;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic              m_arvalid;
   logic              m_rready;
   logic [DATA_W-1:0] r_data;
   logic              ar_hs, aw_hs, r_last_hs, b_hs;

   assign rd_active = (state == IFU_RD) || (state == LSU_RD);
   assign rd_lsu    = (state == LSU_RD);
   assign wr_active = (state == LSU_WR);

   // Both read states share the same routing; only the source bundle differs.
   always_comb begin
      m_araddr  = rd_lsu ? lsu.araddr  : ifu.araddr;
      m_arid    = rd_lsu ? lsu.arid    : ifu.arid;
      m_arlen   = rd_lsu ? lsu.arlen   : ifu.arlen;
      m_arsize  = rd_lsu ? lsu.arsize  : ifu.arsize;
      m_arburst = rd_lsu ? lsu.arburst : ifu.arburst;
      m_arvalid = rd_lsu ? lsu.arvalid : ifu.arvalid;
      m_rready  = rd_lsu ? lsu.rready  : ifu.rready;
   end

   assign r_data = rd_active ? s.rdata : '0;

   // Handshakes are formed from the sources so the output block stays loop-free.
   // addr_acc masks the address valid so a held master valid cannot re-issue.
   assign ar_hs     = rd_active & m_arvalid & ~addr_acc & s.arready;
   assign aw_hs     = wr_active & lsu.awvalid & ~addr_acc & s.awready;
   assign r_last_hs = rd_active & s.rvalid & m_rready & s.rlast;
   assign b_hs      = wr_active & s.bvalid & lsu.bready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         addr_acc <= 1'b0;
      end else begin
         state    <= state_next;
         addr_acc <= addr_acc_next;
      end
   end

   always_comb begin
      state_next    = state;
      addr_acc_next = addr_acc;
      case (state)
         IDLE: begin
            addr_acc_next = 1'b0;
            if (lsu.awvalid)      state_next = LSU_WR;
            else if (lsu.arvalid) state_next = LSU_RD;
            else if (ifu.arvalid) state_next = IFU_RD;
         end
         IFU_RD, LSU_RD: begin
            if (ar_hs) addr_acc_next = 1'b1;
            if (r_last_hs) begin
               state_next    = IDLE;
               addr_acc_next = 1'b0;
            end
         end
         LSU_WR: begin
            if (aw_hs) addr_acc_next = 1'b1;
            if (b_hs) begin
               state_next    = IDLE;
               addr_acc_next = 1'b0;
            end
         end
         default: begin
            state_next    = IDLE;
            addr_acc_next = 1'b0;
         end
      endcase
   end

   always_comb begin
      s.araddr    = '0;
      s.arvalid   = 1'b0;
      s.arid      = '0;
      s.arlen     = '0;
      s.arsize    = '0;
      s.arburst   = '0;
      s.rready    = 1'b0;
      s.awaddr    = '0;
      s.awvalid   = 1'b0;
      s.awid      = '0;
      s.awlen     = '0;
      s.awsize    = '0;
      s.awburst   = '0;
      s.wdata     = '0;
      s.wstrb     = '0;
      s.wlast     = 1'b0;
      s.wvalid    = 1'b0;
      s.bready    = 1'b0;
      ifu.arready = 1'b0;
      ifu.rdata   = '0;
      ifu.rresp   = '0;
      ifu.rvalid  = 1'b0;
      ifu.rid     = '0;
      ifu.rlast   = 1'b0;
      lsu.arready = 1'b0;
      lsu.rdata   = '0;
      lsu.rresp   = '0;
      lsu.rvalid  = 1'b0;
      lsu.rid     = '0;
      lsu.rlast   = 1'b0;
      lsu.awready = 1'b0;
      lsu.wready  = 1'b0;
      lsu.bresp   = '0;
      lsu.bvalid  = 1'b0;
      lsu.bid     = '0;

      if (rd_active) begin
         s.araddr  = m_araddr;
         s.arvalid = m_arvalid & ~addr_acc;
         s.arid    = m_arid;
         s.arlen   = m_arlen;
         s.arsize  = m_arsize;
         s.arburst = m_arburst;
         s.rready  = m_rready;
         if (rd_lsu) begin
            lsu.arready = s.arready & ~addr_acc;
            lsu.rdata   = r_data;
            lsu.rresp   = s.rresp;
            lsu.rvalid  = s.rvalid;
            lsu.rid     = s.rid;
            lsu.rlast   = s.rlast;
         end else begin
            ifu.arready = s.arready & ~addr_acc;
            ifu.rdata   = r_data;
            ifu.rresp   = s.rresp;
            ifu.rvalid  = s.rvalid;
            ifu.rid     = s.rid;
            ifu.rlast   = s.rlast;
         end
      end

      // AW and W are independent: either may be accepted first.
      if (wr_active) begin
         s.awaddr    = lsu.awaddr;
         s.awvalid   = lsu.awvalid & ~addr_acc;
         s.awid      = lsu.awid;
         s.awlen     = lsu.awlen;
         s.awsize    = lsu.awsize;
         s.awburst   = lsu.awburst;
         lsu.awready = s.awready & ~addr_acc;
         s.wdata     = lsu.wdata;
         s.wstrb     = lsu.wstrb;
         s.wlast     = lsu.wlast;
         s.wvalid    = lsu.wvalid;
         lsu.wready  = s.wready;
         lsu.bresp   = s.bresp;
         lsu.bvalid  = s.bvalid;
         lsu.bid     = s.bid;
         s.bready    = lsu.bready;
      end
   end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter with an expected-value queue: expectations
// are pushed as stimulus is driven and popped when the DUT presents output.
module tb_axi_arbiter;
   import axi_arb_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;
   exp_t exp_q[$];

   axi_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) ifu_if ();
   axi_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) lsu_if ();
   axi_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();

   axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .ifu   (ifu_if),
      .lsu   (lsu_if),
      .s     (s_if)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input logic [63:0] got);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   // Drive a single R beat from the slave and hold it for one cycle.
   task automatic r_beat(input logic [31:0] data, input logic [3:0] id, input logic last);
      s_if.rvalid = 1'b1;
      s_if.rdata  = data;
      s_if.rid    = id;
      s_if.rresp  = RESP_OKAY;
      s_if.rlast  = last;
   endtask

   task automatic r_idle();
      s_if.rvalid = 1'b0;
      s_if.rdata  = '0;
      s_if.rlast  = 1'b0;
      s_if.rid    = '0;
      s_if.rresp  = RESP_OKAY;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      ifu_if.araddr = '0; ifu_if.arvalid = 0; ifu_if.arid = '0; ifu_if.arlen = '0;
      ifu_if.arsize = 3'd2; ifu_if.arburst = BURST_INCR; ifu_if.rready = 0;
      lsu_if.araddr = '0; lsu_if.arvalid = 0; lsu_if.arid = '0; lsu_if.arlen = '0;
      lsu_if.arsize = 3'd2; lsu_if.arburst = BURST_INCR; lsu_if.rready = 0;
      lsu_if.awaddr = '0; lsu_if.awvalid = 0; lsu_if.awid = '0; lsu_if.awlen = '0;
      lsu_if.awsize = 3'd2; lsu_if.awburst = BURST_INCR;
      lsu_if.wdata = '0; lsu_if.wstrb = '0; lsu_if.wlast = 0; lsu_if.wvalid = 0;
      lsu_if.bready = 0;
      s_if.arready = 0; s_if.awready = 0; s_if.wready = 0;
      s_if.bvalid = 0; s_if.bresp = RESP_OKAY; s_if.bid = '0;
      r_idle();

      // ---------------- reset holds everything quiet ----------------
      ifu_if.arvalid = 1; ifu_if.araddr = 32'h1111_0000;
      repeat (3) cyc();
      smp();
      check("rst_s_arvalid", s_if.arvalid, 0);
      check("rst_ifu_arready", ifu_if.arready, 0);
      check("rst_s_araddr", s_if.araddr, 0);
      check("rst_state", dut.state, IDLE);
      cyc();
      ifu_if.arvalid = 0; ifu_if.araddr = '0;
      cyc();
      reset = 0;
      cyc();

      // ---------------- IFU single read ----------------
      s_if.arready = 1;
      ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0000; ifu_if.arid = 4'h5; ifu_if.arlen = 0;
      push("t1_araddr", 32'h3000_0000);
      smp();
      check("t1_lat_idle", s_if.arvalid, 0);
      cyc();
      smp();
      check("t1_s_arvalid", s_if.arvalid, 1);
      pop_check(s_if.araddr);
      check("t1_s_arid", s_if.arid, 4'h5);
      check("t1_ifu_arready", ifu_if.arready, 1);
      cyc();
      ifu_if.arvalid = 0;
      ifu_if.rready = 1;
      r_beat(32'hDEAD_BEEF, 4'h5, 1);
      push("t1_rdata", 32'hDEAD_BEEF);
      smp();
      pop_check(ifu_if.rdata);
      check("t1_rvalid", ifu_if.rvalid, 1);
      check("t1_rlast", ifu_if.rlast, 1);
      check("t1_lsu_rvalid", lsu_if.rvalid, 0);
      cyc();
      r_idle(); ifu_if.rready = 0;
      smp();
      check("t1_idle", dut.state, IDLE);
      cyc();

      // ---------------- LSU store ----------------
      s_if.awready = 1; s_if.wready = 1;
      lsu_if.awvalid = 1; lsu_if.awaddr = 32'h8000_0004; lsu_if.awid = 4'h3;
      lsu_if.wvalid = 1; lsu_if.wdata = 32'h1234_0000; lsu_if.wstrb = 4'b1100; lsu_if.wlast = 1;
      lsu_if.bready = 1;
      push("t2_awaddr", 32'h8000_0004);
      push("t2_wdata", 32'h1234_0000);
      push("t2_wstrb", 4'b1100);
      smp();
      check("t2_lat_idle", s_if.awvalid, 0);
      cyc();
      smp();
      check("t2_s_awvalid", s_if.awvalid, 1);
      pop_check(s_if.awaddr);
      check("t2_s_wvalid", s_if.wvalid, 1);
      pop_check(s_if.wdata);
      pop_check(s_if.wstrb);
      check("t2_lsu_awready", lsu_if.awready, 1);
      check("t2_lsu_wready", lsu_if.wready, 1);
      check("t2_ifu_arready", ifu_if.arready, 0);
      check("t2_ifu_rvalid", ifu_if.rvalid, 0);
      cyc();
      lsu_if.awvalid = 0; lsu_if.wvalid = 0; lsu_if.wlast = 0;
      s_if.bvalid = 1; s_if.bresp = RESP_OKAY; s_if.bid = 4'h3;
      push("t2_bid", 4'h3);
      smp();
      check("t2_lsu_bvalid", lsu_if.bvalid, 1);
      pop_check(lsu_if.bid);
      check("t2_lsu_bresp", lsu_if.bresp, RESP_OKAY);
      check("t2_ifu_rvalid_b", ifu_if.rvalid, 0);
      cyc();
      s_if.bvalid = 0; s_if.bid = '0; lsu_if.bready = 0;
      smp();
      check("t2_idle", dut.state, IDLE);
      cyc();

      // ---------------- collision, LSU wins, error response ----------------
      ifu_if.arvalid = 1; ifu_if.araddr = 32'hA000_0000; ifu_if.arid = 4'h1;
      lsu_if.arvalid = 1; lsu_if.araddr = 32'h4000_0010; lsu_if.arid = 4'h2;
      push("t3_lsu_araddr", 32'h4000_0010);
      cyc();
      smp();
      check("t3_state_lsu", dut.state, LSU_RD);
      pop_check(s_if.araddr);
      check("t3_ifu_arready", ifu_if.arready, 0);
      check("t3_lsu_arready", lsu_if.arready, 1);
      cyc();
      lsu_if.arvalid = 0;
      lsu_if.rready = 1;
      r_beat(32'hCAFE_0001, 4'h2, 1);
      s_if.rresp = RESP_SLVERR;
      push("t3_lsu_rdata", 32'hCAFE_0001);
      smp();
      pop_check(lsu_if.rdata);
      check("t3_lsu_rresp", lsu_if.rresp, RESP_SLVERR);
      check("t3_ifu_rvalid", ifu_if.rvalid, 0);
      check("t3_s_arvalid_mask", s_if.arvalid, 0);
      cyc();
      r_idle(); lsu_if.rready = 0;
      smp();
      check("t3_bubble_arvalid", s_if.arvalid, 0);
      check("t3_bubble_state", dut.state, IDLE);
      push("t3_ifu_araddr", 32'hA000_0000);
      cyc();
      smp();
      check("t3_ifu_arvalid", s_if.arvalid, 1);
      pop_check(s_if.araddr);
      check("t3_state_ifu", dut.state, IFU_RD);
      cyc();
      ifu_if.arvalid = 0;
      ifu_if.rready = 1;
      r_beat(32'h0000_00A1, 4'h1, 1);
      smp();
      check("t3_ifu_rvalid2", ifu_if.rvalid, 1);
      cyc();
      r_idle(); ifu_if.rready = 0;
      cyc();

      // ---------------- IFU burst, LSU waits ----------------
      ifu_if.arvalid = 1; ifu_if.araddr = 32'h0000_1000; ifu_if.arid = 4'h7; ifu_if.arlen = 8'd3;
      cyc();
      smp();
      check("t4_s_arlen", s_if.arlen, 8'd3);
      cyc();
      ifu_if.arvalid = 0; ifu_if.arlen = 0;
      ifu_if.rready = 1;
      for (int i = 0; i < 4; i++) begin
         r_beat(32'hB000_0000 + 32'(i), 4'h7, i == 3);
         if (i == 1) begin
            lsu_if.arvalid = 1; lsu_if.araddr = 32'h5000_0000; lsu_if.arid = 4'h9;
         end
         push("t4_rdata", 32'hB000_0000 + 64'(i));
         smp();
         pop_check(ifu_if.rdata);
         check("t4_state_held", dut.state, IFU_RD);
         check("t4_lsu_arready", lsu_if.arready, 0);
         cyc();
      end
      r_idle(); ifu_if.rready = 0;
      smp();
      check("t4_bubble_state", dut.state, IDLE);
      check("t4_bubble_arvalid", s_if.arvalid, 0);
      push("t4_lsu_araddr", 32'h5000_0000);
      cyc();
      smp();
      check("t4_state_lsu", dut.state, LSU_RD);
      pop_check(s_if.araddr);
      cyc();
      lsu_if.arvalid = 0;
      lsu_if.rready = 1;
      r_beat(32'h0000_0055, 4'h9, 1);
      smp();
      check("t4_lsu_rvalid", lsu_if.rvalid, 1);
      cyc();
      r_idle(); lsu_if.rready = 0;
      cyc();

      // ---------------- stalled slave ----------------
      s_if.arready = 0;
      ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0040; ifu_if.arid = 4'h2;
      cyc();
      for (int i = 0; i < 5; i++) begin
         push("t5_araddr_stable", 32'h3000_0040);
         smp();
         check("t5_arvalid_held", s_if.arvalid, 1);
         pop_check(s_if.araddr);
         check("t5_ifu_arready", ifu_if.arready, 0);
         cyc();
      end
      s_if.arready = 1;
      smp();
      check("t5_arvalid_acc", s_if.arvalid, 1);
      check("t5_ifu_arready_acc", ifu_if.arready, 1);
      cyc();
      smp();
      check("t5_arvalid_masked", s_if.arvalid, 0);
      check("t5_ifu_arready_masked", ifu_if.arready, 0);
      cyc();
      ifu_if.arvalid = 0;
      ifu_if.rready = 1;
      r_beat(32'h0000_0777, 4'h2, 1);
      smp();
      check("t5_rvalid", ifu_if.rvalid, 1);
      cyc();
      r_idle(); ifu_if.rready = 0;
      cyc();

      // ---------------- reset mid LSU_WR ----------------
      s_if.awready = 1; s_if.wready = 0;
      lsu_if.awvalid = 1; lsu_if.awaddr = 32'h8000_0100; lsu_if.awid = 4'h4;
      cyc();
      smp();
      check("t6_s_awvalid", s_if.awvalid, 1);
      cyc();
      lsu_if.awvalid = 0;
      lsu_if.wvalid = 1; lsu_if.wdata = 32'h0BAD_0BAD; lsu_if.wstrb = 4'hF; lsu_if.wlast = 1;
      lsu_if.bready = 1;
      smp();
      check("t6_awvalid_masked", s_if.awvalid, 0);
      reset = 1;
      cyc();
      reset = 0;
      lsu_if.wvalid = 0; lsu_if.wdata = '0; lsu_if.wstrb = '0; lsu_if.wlast = 0;
      lsu_if.bready = 0;
      smp();
      check("t6_state", dut.state, IDLE);
      check("t6_addr_acc", dut.addr_acc, 0);
      check("t6_s_wvalid", s_if.wvalid, 0);
      check("t6_s_awaddr", s_if.awaddr, 0);
      check("t6_lsu_awready", lsu_if.awready, 0);
      check("t6_s_bready", s_if.bready, 0);
      ifu_if.arvalid = 1; ifu_if.araddr = 32'h3000_0080; ifu_if.arid = 4'h6;
      push("t6_ifu_araddr", 32'h3000_0080);
      cyc();
      smp();
      check("t6_ifu_arvalid", s_if.arvalid, 1);
      pop_check(s_if.araddr);
      cyc();
      ifu_if.arvalid = 0;
      ifu_if.rready = 1;
      r_beat(32'h600D_0001, 4'h6, 1);
      push("t6_ifu_rdata", 32'h600D_0001);
      smp();
      pop_check(ifu_if.rdata);
      cyc();
      r_idle(); ifu_if.rready = 0;
      smp();
      check("t6_final_idle", dut.state, IDLE);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
